// File: rtl/inst_fetch.sv
// Instruction-fetch stage with a one-entry fetch buffer and the IF/ID pipeline register.
// Redirects that land while a read is in flight wait out the stale ack in S_DISCARD.
module inst_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        id_rst,
  input  logic        id_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic        id_valid,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_next_id
);

  typedef enum logic {S_FETCH, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        id_valid_q, id_valid_d;

  logic        consume;
  logic        ack;
  logic [31:0] redirect_tgt;

  always_comb begin
    consume      = if_en & id_en & buf_valid_q & ~redirect;
    imem_req     = ~rst & ~if_rst & ((state_q == S_DISCARD) | ~buf_valid_q | consume);
    ack          = imem_ack & imem_req;
    redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    buf_valid_d  = buf_valid_q;

    if (rst | if_rst) begin
      state_d      = S_FETCH;
      fetch_pc_d   = PC_RESET;
      pending_pc_d = 32'h0;
      buf_valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (redirect) begin
            buf_valid_d = 1'b0;
            // An unacked request must complete at the old address before retargeting.
            if (imem_req & ~imem_ack) begin
              pending_pc_d = redirect_tgt;
              state_d      = S_DISCARD;
            end else begin
              fetch_pc_d = redirect_tgt;
            end
          end else if (ack) begin
            buf_inst_d  = imem_data;
            buf_pc_d    = fetch_pc_q;
            buf_valid_d = 1'b1;
            fetch_pc_d  = fetch_pc_q + 32'd4;
          end else if (consume) begin
            buf_valid_d = 1'b0;
          end
        end
        S_DISCARD: begin
          buf_valid_d = 1'b0;
          if (ack) begin
            fetch_pc_d = redirect ? redirect_tgt : pending_pc_q;
            state_d    = S_FETCH;
          end else if (redirect) begin
            pending_pc_d = redirect_tgt;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    inst_id_d  = inst_id_q;
    pc_id_d    = pc_id_q;
    id_valid_d = id_valid_q;
    if (rst | id_rst) begin
      inst_id_d  = 32'h0;
      pc_id_d    = 32'h0;
      id_valid_d = 1'b0;
    end else if (id_en & consume) begin
      inst_id_d  = buf_inst_q;
      pc_id_d    = buf_pc_q;
      id_valid_d = 1'b1;
    end else if (id_en) begin
      inst_id_d  = 32'h0;
      pc_id_d    = 32'h0;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    fetch_pc_q   <= fetch_pc_d;
    pending_pc_q <= pending_pc_d;
    buf_inst_q   <= buf_inst_d;
    buf_pc_q     <= buf_pc_d;
    buf_valid_q  <= buf_valid_d;
    inst_id_q    <= inst_id_d;
    pc_id_q      <= pc_id_d;
    id_valid_q   <= id_valid_d;
  end

  assign imem_addr  = fetch_pc_q;
  assign if_valid   = buf_valid_q;
  assign id_valid   = id_valid_q;
  assign inst_id    = inst_id_q;
  assign pc_id      = pc_id_q;
  assign pc_next_id = pc_id_q + 32'd4;

endmodule
